// File: rtl/batch_sum_accumulator_pkg.sv
// Shared widths, limits and error-flag indices for the batch sum accumulator.
package batch_sum_accumulator_pkg;

  localparam int SUM_WIDTH           = 48;
  localparam int ITEM_COUNT_WIDTH    = 9;
  localparam int CONNECT_COUNT_WIDTH = 6;
  localparam int RESULT_WIDTH        = SUM_WIDTH + ITEM_COUNT_WIDTH;

  localparam logic [CONNECT_COUNT_WIDTH-1:0] MAX_CONNECT_COUNT = 6'd35;

  localparam int ERR_ILLEGAL_COUNT = 0;
  localparam int ERR_FIFO_OVERFLOW = 1;

  typedef struct packed {
    logic [SUM_WIDTH-1:0]        sum;
    logic [ITEM_COUNT_WIDTH-1:0] itemCount;
  } result_t;

endpackage

// File: rtl/batch_sum_accumulator_if.sv
// Count stream from the permuter side plus the show-ahead result handshake.
interface batch_sum_accumulator_if;
  import batch_sum_accumulator_pkg::*;

  logic [CONNECT_COUNT_WIDTH-1:0] connectCount;
  logic                           connectCountValid;
  logic                           batchFinished;
  logic                           requestSlowDown;
  logic [SUM_WIDTH-1:0]           resultSum;
  logic [ITEM_COUNT_WIDTH-1:0]    resultItemCount;
  logic                           resultValid;
  logic                           resultReady;
  logic [1:0]                     errorFlags;

  modport master (
    output connectCount, connectCountValid, batchFinished, resultReady,
    input  requestSlowDown, resultSum, resultItemCount, resultValid, errorFlags
  );

  modport slave (
    input  connectCount, connectCountValid, batchFinished, resultReady,
    output requestSlowDown, resultSum, resultItemCount, resultValid, errorFlags
  );

endinterface

// File: rtl/batch_sum_accumulator_fifo.sv
// Generic FIFO with a show-ahead head register; usedw counts the head entry too.
module batch_sum_accumulator_fifo #(
  parameter int WIDTH      = 57,
  parameter int DEPTH_LOG2 = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wrReq,
  input  logic [WIDTH-1:0]      wrData,
  output logic                  overflow,
  input  logic                  rdReq,
  output logic [WIDTH-1:0]      rdData,
  output logic                  rdValid,
  output logic [DEPTH_LOG2:0]   usedw
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2:0]   wrPtr, rdPtr, memCount;
  logic [WIDTH-1:0]      headData;
  logic                  headValid;
  logic                  pop, loadHead, wrAccept;

  assign memCount = wrPtr - rdPtr;
  assign usedw    = memCount + {{DEPTH_LOG2{1'b0}}, headValid};
  assign pop      = headValid && rdReq;
  // Head refills whenever it is empty or being consumed, so it never stalls a pop.
  assign loadHead = (memCount != '0) && (!headValid || pop);
  assign wrAccept = wrReq && ((usedw != FULL_LEVEL) || pop);
  assign overflow = wrReq && !wrAccept;

  assign rdValid = headValid;
  assign rdData  = headValid ? headData : '0;

  always_ff @(posedge clk) begin
    if (wrAccept) mem[wrPtr[DEPTH_LOG2-1:0]] <= wrData;
    if (loadHead) headData <= mem[rdPtr[DEPTH_LOG2-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      headValid <= 1'b0;
    end else begin
      if (wrAccept) wrPtr <= wrPtr + 1'b1;
      if (loadHead) rdPtr <= rdPtr + 1'b1;
      if (loadHead)  headValid <= 1'b1;
      else if (pop)  headValid <= 1'b0;
    end
  end

endmodule

// File: rtl/batch_sum_accumulator.sv
// Sums 2^connectCount per batch and queues one {sum, itemCount} word per batchFinished.
module batch_sum_accumulator
  import batch_sum_accumulator_pkg::*;
#(
  parameter int FIFO_DEPTH_LOG2    = 5,
  parameter int SLOWDOWN_THRESHOLD = 16
) (
  input logic                     clk,
  input logic                     rst,
  batch_sum_accumulator_if.slave  bus
);

  localparam logic [FIFO_DEPTH_LOG2:0] SLOWDOWN_LEVEL = SLOWDOWN_THRESHOLD[FIFO_DEPTH_LOG2:0];

  function automatic logic [SUM_WIDTH-1:0] termOf(input logic [CONNECT_COUNT_WIDTH-1:0] c);
    termOf = {{(SUM_WIDTH-1){1'b0}}, 1'b1} << c;
  endfunction

  logic                         legalCount;
  logic [SUM_WIDTH-1:0]         termP1;
  logic                         vldP1, closeP1;
  logic [SUM_WIDTH-1:0]         sumAccP2, closeSum;
  logic [ITEM_COUNT_WIDTH-1:0]  cntAccP2, closeCnt;
  logic                         rstFifo, fifoOverflow, slowDown;
  logic [1:0]                   errFlags;
  logic [FIFO_DEPTH_LOG2:0]     usedw;
  result_t                      wrWord, headWord;
  logic [RESULT_WIDTH-1:0]      headBits;

  assign legalCount = bus.connectCount <= MAX_CONNECT_COUNT;

  // Stage 1: decode one item into its power-of-two term
  always_ff @(posedge clk) begin
    if (rst) begin
      termP1  <= '0;
      vldP1   <= 1'b0;
      closeP1 <= 1'b0;
    end else begin
      termP1  <= (bus.connectCountValid && legalCount) ? termOf(bus.connectCount) : '0;
      vldP1   <= bus.connectCountValid && legalCount;
      closeP1 <= bus.batchFinished;
    end
  end

  // Stage 2: accumulate; a closing cycle emits the total including its own item
  assign closeSum = sumAccP2 + termP1;
  assign closeCnt = cntAccP2 + {{(ITEM_COUNT_WIDTH-1){1'b0}}, vldP1};

  always_ff @(posedge clk) begin
    if (rst || closeP1) begin
      sumAccP2 <= '0;
      cntAccP2 <= '0;
    end else begin
      sumAccP2 <= closeSum;
      cntAccP2 <= closeCnt;
    end
  end

  assign wrWord.sum       = closeSum;
  assign wrWord.itemCount = closeCnt;

  always_ff @(posedge clk) begin
    rstFifo <= rst;
  end

  batch_sum_accumulator_fifo #(
    .WIDTH      (RESULT_WIDTH),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk      (clk),
    .rst      (rstFifo),
    .wrReq    (closeP1),
    .wrData   (wrWord),
    .overflow (fifoOverflow),
    .rdReq    (bus.resultReady),
    .rdData   (headBits),
    .rdValid  (bus.resultValid),
    .usedw    (usedw)
  );

  assign headWord            = headBits;
  assign bus.resultSum       = headWord.sum;
  assign bus.resultItemCount = headWord.itemCount;

  always_ff @(posedge clk) begin
    if (rst) begin
      errFlags <= '0;
      slowDown <= 1'b0;
    end else begin
      if (bus.connectCountValid && !legalCount) errFlags[ERR_ILLEGAL_COUNT] <= 1'b1;
      if (fifoOverflow)                         errFlags[ERR_FIFO_OVERFLOW] <= 1'b1;
      slowDown <= usedw > SLOWDOWN_LEVEL;
    end
  end

  assign bus.errorFlags      = errFlags;
  assign bus.requestSlowDown = slowDown;

endmodule

// File: tb/tb_batch_sum_accumulator.sv
// Directed bench for batch_sum_accumulator: per-batch sums, boundaries, backpressure, reset.
module tb_batch_sum_accumulator;

  logic clk = 1'b0;
  logic rst;
  int   passCnt = 0;
  int   totalCnt = 0;

  batch_sum_accumulator_if bus();

  batch_sum_accumulator #(
    .FIFO_DEPTH_LOG2    (5),
    .SLOWDOWN_THRESHOLD (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input logic v, input logic [5:0] c, input logic f);
    bus.connectCountValid = v;
    bus.connectCount      = c;
    bus.batchFinished     = f;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 6'd0, 1'b0);
  endtask

  task automatic popWord(output logic ok, output logic [47:0] s, output logic [8:0] n);
    ok = 1'b0;
    s  = '0;
    n  = '0;
    for (int i = 0; i < 20 && !bus.resultValid; i++) idle();
    if (bus.resultValid) begin
      ok = 1'b1;
      s  = bus.resultSum;
      n  = bus.resultItemCount;
      bus.resultReady = 1'b1;
      idle();
      bus.resultReady = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.resultReady = 1'b0;
    step(1'b1, 6'd3, 1'b1);
    step(1'b1, 6'd40, 1'b1);
    step(1'b0, 6'd0, 1'b0);
    step(1'b0, 6'd0, 1'b0);
    totalCnt++; if (bus.resultValid !== 1'b0) $display("FAIL reset_valid got=%0b exp=0", bus.resultValid); else passCnt++;
    totalCnt++; if (bus.requestSlowDown !== 1'b0) $display("FAIL reset_slowdown got=%0b exp=0", bus.requestSlowDown); else passCnt++;
    totalCnt++; if (bus.errorFlags !== 2'b00) $display("FAIL reset_errflags got=%b exp=00", bus.errorFlags); else passCnt++;
    totalCnt++; if (bus.resultSum !== 48'd0) $display("FAIL reset_sum got=%0d exp=0", bus.resultSum); else passCnt++;
    rst = 1'b0;
    idle();
    idle();
  endtask

  task automatic test_basic();
    logic ok; logic [47:0] s; logic [8:0] n;
    step(1'b1, 6'd0, 1'b0);
    step(1'b1, 6'd1, 1'b0);
    step(1'b1, 6'd5, 1'b0);
    step(1'b0, 6'd0, 1'b1);
    idle();
    totalCnt++; if (bus.resultValid !== 1'b0) $display("FAIL basic_valid_n2 got=%0b exp=0", bus.resultValid); else passCnt++;
    idle();
    totalCnt++; if (bus.resultValid !== 1'b1) $display("FAIL basic_valid_n3 got=%0b exp=1", bus.resultValid); else passCnt++;
    popWord(ok, s, n);
    totalCnt++; if (ok !== 1'b1 || s !== 48'd35 || n !== 9'd3) $display("FAIL basic_word ok=%0b sum=%0d cnt=%0d exp sum=35 cnt=3", ok, s, n); else passCnt++;
    totalCnt++; if (bus.resultValid !== 1'b0) $display("FAIL basic_drained got=%0b exp=0", bus.resultValid); else passCnt++;
    totalCnt++; if (bus.errorFlags !== 2'b00) $display("FAIL basic_errflags got=%b exp=00", bus.errorFlags); else passCnt++;
  endtask

  task automatic test_empty_batches();
    logic ok; logic [47:0] s; logic [8:0] n;
    step(1'b0, 6'd0, 1'b1);
    step(1'b0, 6'd0, 1'b1);
    popWord(ok, s, n);
    totalCnt++; if (ok !== 1'b1 || s !== 48'd0 || n !== 9'd0) $display("FAIL empty_word0 ok=%0b sum=%0d cnt=%0d exp sum=0 cnt=0", ok, s, n); else passCnt++;
    popWord(ok, s, n);
    totalCnt++; if (ok !== 1'b1 || s !== 48'd0 || n !== 9'd0) $display("FAIL empty_word1 ok=%0b sum=%0d cnt=%0d exp sum=0 cnt=0", ok, s, n); else passCnt++;
    idle(); idle(); idle();
    totalCnt++; if (bus.resultValid !== 1'b0) $display("FAIL empty_no_extra got=%0b exp=0", bus.resultValid); else passCnt++;
  endtask

  task automatic test_boundary();
    logic ok; logic [47:0] s; logic [8:0] n;
    logic [47:0] big;
    big = 48'd1 << 35;
    step(1'b1, 6'd35, 1'b1);
    step(1'b1, 6'd2, 1'b0);
    step(1'b0, 6'd0, 1'b1);
    popWord(ok, s, n);
    totalCnt++; if (ok !== 1'b1 || s !== big || n !== 9'd1) $display("FAIL boundary_word0 ok=%0b sum=%0d cnt=%0d exp sum=%0d cnt=1", ok, s, n, big); else passCnt++;
    popWord(ok, s, n);
    totalCnt++; if (ok !== 1'b1 || s !== 48'd4 || n !== 9'd1) $display("FAIL boundary_word1 ok=%0b sum=%0d cnt=%0d exp sum=4 cnt=1", ok, s, n); else passCnt++;
  endtask

  task automatic test_illegal();
    logic ok; logic [47:0] s; logic [8:0] n;
    step(1'b1, 6'd40, 1'b0);
    step(1'b0, 6'd0, 1'b1);
    popWord(ok, s, n);
    totalCnt++; if (ok !== 1'b1 || s !== 48'd0 || n !== 9'd0) $display("FAIL illegal_word ok=%0b sum=%0d cnt=%0d exp sum=0 cnt=0", ok, s, n); else passCnt++;
    totalCnt++; if (bus.errorFlags !== 2'b01) $display("FAIL illegal_flag got=%b exp=01", bus.errorFlags); else passCnt++;
    for (int i = 0; i < 5; i++) idle();
    totalCnt++; if (bus.errorFlags !== 2'b01) $display("FAIL illegal_sticky got=%b exp=01", bus.errorFlags); else passCnt++;
  endtask

  task automatic test_backpressure();
    logic ok; logic [47:0] s; logic [8:0] n;
    logic [47:0] one;
    logic [47:0] expSum;
    one = 48'd1;
    bus.resultReady = 1'b0;
    for (int i = 0; i < 17; i++) step(1'b1, 6'(i), 1'b1);
    idle();
    totalCnt++; if (bus.requestSlowDown !== 1'b0) $display("FAIL slowdown_at_usedw17 got=%0b exp=0", bus.requestSlowDown); else passCnt++;
    idle();
    totalCnt++; if (bus.requestSlowDown !== 1'b1) $display("FAIL slowdown_after_usedw17 got=%0b exp=1", bus.requestSlowDown); else passCnt++;
    for (int i = 17; i < 33; i++) step(1'b1, 6'(i), 1'b1);
    idle();
    totalCnt++; if (bus.errorFlags !== 2'b11) $display("FAIL overflow_flag got=%b exp=11", bus.errorFlags); else passCnt++;
    totalCnt++; if (bus.resultSum !== 48'd1 || bus.resultItemCount !== 9'd1) $display("FAIL held_head sum=%0d cnt=%0d exp sum=1 cnt=1", bus.resultSum, bus.resultItemCount); else passCnt++;
    for (int i = 0; i < 32; i++) begin
      popWord(ok, s, n);
      expSum = one << i;
      totalCnt++; if (ok !== 1'b1 || s !== expSum || n !== 9'd1) $display("FAIL full_word%0d ok=%0b sum=%0d cnt=%0d exp sum=%0d cnt=1", i, ok, s, n, expSum); else passCnt++;
    end
    idle(); idle();
    totalCnt++; if (bus.resultValid !== 1'b0) $display("FAIL overflow_dropped got=%0b exp=0", bus.resultValid); else passCnt++;
    totalCnt++; if (bus.requestSlowDown !== 1'b0) $display("FAIL slowdown_release got=%0b exp=0", bus.requestSlowDown); else passCnt++;
  endtask

  task automatic test_reset_mid_batch();
    logic ok; logic [47:0] s; logic [8:0] n;
    step(1'b1, 6'd3, 1'b0);
    step(1'b1, 6'd3, 1'b0);
    step(1'b1, 6'd3, 1'b0);
    rst = 1'b1;
    step(1'b1, 6'd7, 1'b1);
    step(1'b1, 6'd40, 1'b1);
    step(1'b1, 6'd7, 1'b1);
    totalCnt++; if (bus.resultValid !== 1'b0) $display("FAIL midrst_valid got=%0b exp=0", bus.resultValid); else passCnt++;
    totalCnt++; if (bus.errorFlags !== 2'b00) $display("FAIL midrst_errflags got=%b exp=00", bus.errorFlags); else passCnt++;
    totalCnt++; if (bus.requestSlowDown !== 1'b0) $display("FAIL midrst_slowdown got=%0b exp=0", bus.requestSlowDown); else passCnt++;
    rst = 1'b0;
    step(1'b1, 6'd4, 1'b0);
    step(1'b0, 6'd0, 1'b1);
    popWord(ok, s, n);
    totalCnt++; if (ok !== 1'b1 || s !== 48'd16 || n !== 9'd1) $display("FAIL midrst_word ok=%0b sum=%0d cnt=%0d exp sum=16 cnt=1", ok, s, n); else passCnt++;
    idle(); idle(); idle();
    totalCnt++; if (bus.resultValid !== 1'b0) $display("FAIL midrst_single got=%0b exp=0", bus.resultValid); else passCnt++;
  endtask

  initial begin
    rst = 1'b1;
    bus.connectCount      = '0;
    bus.connectCountValid = 1'b0;
    bus.batchFinished     = 1'b0;
    bus.resultReady       = 1'b0;
    test_reset();
    test_basic();
    test_empty_batches();
    test_boundary();
    test_illegal();
    test_backpressure();
    test_reset_mid_batch();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

// File: doc/batch_sum_accumulator.md
# batch_sum_accumulator

Downstream consumer of the bot permuter stage. It takes the per-permutation connect-count stream produced by the counting pipeline after the permuter, computes 2^count for each valid item, and sums these terms per batch, with batch boundaries marked by the permuter's batchFinished pulse. Each finished batch produces one {sum, itemCount} word, buffered in an output FIFO. Backpressure to the permuter is raised through requestSlowDown.

## Interface
- FIFO_DEPTH_LOG2, 5, log2 depth of the output result FIFO
- SLOWDOWN_THRESHOLD, 16, FIFO occupancy above which requestSlowDown asserts
- clk  in  1  single clock domain
- rst  in  1  synchronous, active-high reset
- connectCount  in  6  connect count of one permuted bot; legal values 0..35
- connectCountValid  in  1  connectCount carries one item this cycle
- batchFinished  in  1  pulse that closes the current batch; a valid item in the same cycle belongs to the closing batch
- requestSlowDown  out  1  registered; 1 while FIFO usedw > SLOWDOWN_THRESHOLD
- resultSum  out  48  sum of 2^connectCount over the batch
- resultItemCount  out  9  number of valid items in the batch (max 378 = 63 bots × 6 permutes)
- resultValid  out  1  show-ahead FIFO output is valid
- resultReady  in  1  consumer pops the head word when resultValid && resultReady
- errorFlags  out  2  sticky; bit0 = illegal count (≥36) seen, bit1 = FIFO overflow

## Operation
- Stage 1 (registered): term = connectCountValid && connectCount<36 ? 48'b1<<connectCount : 0; incr = connectCountValid && connectCount<36. Also registers close = batchFinished.
- Illegal count: contributes term 0, does not increment the item count, and sets errorFlags[0].
- Stage 2 accumulator:
  - not close: sumAcc += term, cntAcc += incr.
  - close: write {sumAcc+term, cntAcc+incr} to the FIFO, then load sumAcc <= 0, cntAcc <= 0.
- Empty batch (close with no items since the last close) writes {0, 0}.
- Consecutive batchFinished pulses write one entry each.
- An item in the cycle after a close goes to the new batch; no item is lost or double-counted.
- Arithmetic is unsigned. A 48-bit sum cannot overflow for ≤378 items of ≤2^35 each. cntAcc is 9 bits, saturating not required.
- FIFO write while full: the entry is dropped, errorFlags[1] is set, and the FIFO contents are unchanged.
- Pop and write in the same cycle are both honoured; usedw is unchanged.
- Reset clears the accumulators, stage registers, FIFO (resultValid=0), requestSlowDown=0 and errorFlags=0.
- Reset mid-batch discards the partial batch. Inputs during rst are ignored.

## Timing
- batchFinished at cycle N → FIFO write at N+2 → resultValid at N+3 when the FIFO was empty.
- An item at cycle N is included in a batch closed at or after N.
- requestSlowDown lags usedw by 1 cycle.
- With threshold 16 and depth 32, upstream gets ≥15 entries of slack for in-flight batches.
- Output is a show-ahead handshake: resultSum and resultItemCount are stable while resultValid && !resultReady.
- Throughput is one item per cycle and one batch close per cycle, sustained.

## Structure
- A shared package holds SUM_WIDTH=48, ITEM_COUNT_WIDTH=9, MAX_CONNECT_COUNT=35 and the errorFlags bit indices.
- The output FIFO instantiates the codebase's generic FIFO (WIDTH=57, DEPTH_LOG2=FIFO_DEPTH_LOG2, show-ahead output register).
- The stage-1 decode and the stage-2 accumulator stay in this module.
- The FIFO reset is a locally registered copy of rst.

## Test plan
- Counts 0, 1, 5 valid, then batchFinished → one word {sum=1+2+32=35, itemCount=3}, resultValid at N+3.
- batchFinished with no prior items, followed by another batchFinished next cycle → two words {0, 0}.
- Item count=35 in the same cycle as batchFinished, item count=2 the next cycle, then close → words {2^35, 1} then {4, 1}.
- connectCount=40 valid, then close → {0, 0} and errorFlags=2'b01 stays set.
- Hold resultReady=0 and issue 17 closes → requestSlowDown=1 one cycle after usedw=17. Issue 33 closes → errorFlags[1]=1 and the first 32 words pop intact.
- rst asserted mid-batch after 3 items, then 1 item and close → single word {that item's term, 1}, outputs 0 during reset.
